mwb_stage: RTL and testbench

- Memory/writeback stage of the three-stage RISC-V pipeline. It consumes the EXE→MWB pipeline register outputs and the synchronous data-memory read data.
- Functions: load alignment and extension, writeback-source selection, register-file write-port generation, load-wait stall FSM, one-entry forwarding register for the next instruction, and a retired-instruction counter.
- Stores were already issued to memory in EXE. Here they only retire.

---
 rtl/mwb_stage.sv | 183 ++++++++++++++++++
 tb/tb_mwb_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mwb_stage.sv
//==============================================================================
// Module      : mwb_stage
// Description : Memory/writeback stage. Handles load alignment, writeback
//               selection, load-wait stalling, forwarding and retirement.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mwb_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            reg_we_in,
  input  logic [1:0]      dmem_sel_in,
  input  logic [2:0]      load_sel_in,
  input  logic [1:0]      wb_sel_in,
  input  logic [31:0]     dmem_rdata,
  input  logic            dmem_rvalid,
  output logic            stall,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_addr,
  output logic [XLEN-1:0] fwd_data,
  output logic            misaligned_err,
  output logic [31:0]     retire_count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] DMEM_LOAD = 2'b01;
  localparam logic [1:0] WB_LOAD   = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
  localparam logic [2:0] F3_LB     = 3'b000;
  localparam logic [2:0] F3_LH     = 3'b001;
  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_LBU    = 3'b100;
  localparam logic [2:0] F3_LHU    = 3'b101;

  state_t            state_q, state_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [4:0]        fwd_addr_q, fwd_addr_d;
  logic [XLEN-1:0]   fwd_data_q, fwd_data_d;
  logic              misaligned_err_q, misaligned_err_d;
  logic [31:0]       retire_count_q, retire_count_d;

  logic              is_load;
  logic              is_bubble;
  logic              complete;
  logic              misaligned;
  logic [1:0]        off;
  logic [31:0]       shifted_word;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   wb_value;
  logic              we_ok;

  assign is_bubble = (instruction_in == 32'd0);
  assign is_load   = (dmem_sel_in == DMEM_LOAD) && !is_bubble;
  assign off       = alu_result_in[1:0];

  // Load wait FSM: stall holds the instruction until its read data shows up.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (is_load && !dmem_rvalid) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = !dmem_rvalid;
        if (dmem_rvalid) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign complete = !stall;

  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      case (load_sel_in)
        F3_LH, F3_LHU: misaligned = off[0];
        F3_LW:         misaligned = (off != 2'b00);
        default:       misaligned = 1'b0;
      endcase
    end
  end

  // Little-endian lanes: shifting by the byte offset lines up the lane at [7:0].
  always_comb begin
    shifted_word = dmem_rdata >> {off, 3'b000};
    sel_byte     = shifted_word[7:0];
    sel_half     = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (load_sel_in)
      F3_LB:   load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LH:   load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, sel_half};
      default: load_data = XLEN'(dmem_rdata);
    endcase
  end

  // PC+4 in full datapath width so the top PC does not wrap.
  assign pc_plus4 = XLEN'(pc_in) + XLEN'(4);

  always_comb begin
    case (wb_sel_in)
      WB_LOAD: wb_value = load_data;
      WB_PC4:  wb_value = pc_plus4;
      default: wb_value = alu_result_in;
    endcase
  end

  assign rf_waddr = instruction_in[11:7];
  assign rf_wdata = wb_value;
  assign we_ok    = reg_we_in && (rf_waddr != 5'd0) && !misaligned;
  assign rf_we    = complete && we_ok;

  always_comb begin
    fwd_valid_d      = rf_we;
    fwd_addr_d       = fwd_addr_q;
    fwd_data_d       = fwd_data_q;
    misaligned_err_d = misaligned_err_q;
    retire_count_d   = retire_count_q;
    if (rf_we) begin
      fwd_addr_d = rf_waddr;
      fwd_data_d = rf_wdata;
    end
    if (complete && misaligned) begin
      misaligned_err_d = 1'b1;
    end
    if (complete && !is_bubble) begin
      retire_count_d = retire_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      fwd_valid_q      <= 1'b0;
      fwd_addr_q       <= 5'd0;
      fwd_data_q       <= '0;
      misaligned_err_q <= 1'b0;
      retire_count_q   <= 32'd0;
    end else begin
      state_q          <= state_d;
      fwd_valid_q      <= fwd_valid_d;
      fwd_addr_q       <= fwd_addr_d;
      fwd_data_q       <= fwd_data_d;
      misaligned_err_q <= misaligned_err_d;
      retire_count_q   <= retire_count_d;
    end
  end

  assign fwd_valid      = fwd_valid_q;
  assign fwd_addr       = fwd_addr_q;
  assign fwd_data       = fwd_data_q;
  assign misaligned_err = misaligned_err_q;
  assign retire_count   = retire_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mwb_stage.sv
//==============================================================================
// Module      : tb_mwb_stage
// Description : Directed self-checking bench for mwb_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mwb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_in;
  logic [31:0] alu_result_in;
  logic [13:0] pc_in;
  logic        reg_we_in;
  logic [1:0]  dmem_sel_in;
  logic [2:0]  load_sel_in;
  logic [1:0]  wb_sel_in;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        misaligned_err;
  logic [31:0] retire_count;

  int vectors = 0;
  int miscompares = 0;

  mwb_stage #(.XLEN(32), .PC_W(14)) dut (
    .clk(clk), .rst(rst),
    .instruction_in(instruction_in), .alu_result_in(alu_result_in),
    .pc_in(pc_in), .reg_we_in(reg_we_in), .dmem_sel_in(dmem_sel_in),
    .load_sel_in(load_sel_in), .wb_sel_in(wb_sel_in),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .misaligned_err(misaligned_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Set up one instruction; inputs change just after a falling edge.
  task automatic drive(input logic [4:0] rd, input logic [1:0] dsel, input logic [2:0] f3,
                       input logic [1:0] wsel, input logic we, input logic [31:0] alu);
    instruction_in = {20'h0, rd, 7'h13};
    dmem_sel_in    = dsel;
    load_sel_in    = f3;
    wb_sel_in      = wsel;
    reg_we_in      = we;
    alu_result_in  = alu;
  endtask

  task automatic bubble;
    instruction_in = 32'd0;
    dmem_sel_in    = 2'b00;
    load_sel_in    = 3'b000;
    wb_sel_in      = 2'b00;
    reg_we_in      = 1'b0;
    alu_result_in  = 32'd0;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bubble();
    pc_in       = 14'd0;
    dmem_rdata  = 32'd0;
    dmem_rvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_fwd_addr", 32'(fwd_addr), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_mis", 32'(misaligned_err), 32'd0);
    chk("rst_retire", retire_count, 32'd0);

    // LB x5, byte 3 of 0x80AABBCC = 0x80 sign-extended
    tick();
    drive(5'd5, 2'b01, 3'b000, 2'b01, 1'b1, 32'h103);
    dmem_rdata = 32'h80AA_BBCC; dmem_rvalid = 1'b1;
    #2;
    chk("lb_stall", 32'(stall), 32'd0);
    chk("lb_we", 32'(rf_we), 32'd1);
    chk("lb_waddr", 32'(rf_waddr), 32'd5);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    tick();
    chk("lb_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("lb_fwd_addr", 32'(fwd_addr), 32'd5);
    chk("lb_fwd_data", fwd_data, 32'hFFFF_FF80);
    chk("lb_retire", retire_count, 32'd1);

    // LHU / LH upper half
    drive(5'd6, 2'b01, 3'b101, 2'b01, 1'b1, 32'h2);
    dmem_rdata = 32'h8001_1234;
    #2;
    chk("lhu_wdata", rf_wdata, 32'h0000_8001);
    chk("lhu_we", 32'(rf_we), 32'd1);
    tick();
    drive(5'd6, 2'b01, 3'b001, 2'b01, 1'b1, 32'h2);
    #2;
    chk("lh_wdata", rf_wdata, 32'hFFFF_8001);
    tick();
    // LBU lane 1 of 0x80011234 -> 0x12
    drive(5'd6, 2'b01, 3'b100, 2'b01, 1'b1, 32'h1);
    #2;
    chk("lbu_wdata", rf_wdata, 32'h0000_0012);
    tick();
    chk("retire_3", retire_count, 32'd4);

    // LW waiting two cycles for data
    drive(5'd7, 2'b01, 3'b010, 2'b01, 1'b1, 32'h0);
    dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
    #2;
    chk("wait1_stall", 32'(stall), 32'd1);
    chk("wait1_we", 32'(rf_we), 32'd0);
    tick();
    chk("wait2_stall", 32'(stall), 32'd1);
    chk("wait2_we", 32'(rf_we), 32'd0);
    chk("wait2_retire", retire_count, 32'd4);
    chk("wait2_fwd_valid", 32'(fwd_valid), 32'd0);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    #2;
    chk("wait3_stall", 32'(stall), 32'd0);
    chk("wait3_we", 32'(rf_we), 32'd1);
    chk("wait3_wdata", rf_wdata, 32'h1234_5678);
    tick();
    chk("wait_retire", retire_count, 32'd5);
    chk("wait_fwd_data", fwd_data, 32'h1234_5678);

    // JAL rd=1 at top PC; then rd=0
    drive(5'd1, 2'b00, 3'b000, 2'b10, 1'b1, 32'h55);
    pc_in = 14'h3FFC; dmem_rvalid = 1'b0;
    #2;
    chk("jal_wdata", rf_wdata, 32'h0000_4000);
    chk("jal_we", 32'(rf_we), 32'd1);
    tick();
    drive(5'd0, 2'b00, 3'b000, 2'b10, 1'b1, 32'h55);
    #2;
    chk("jal0_we", 32'(rf_we), 32'd0);
    tick();
    chk("jal0_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("jal0_fwd_addr_hold", 32'(fwd_addr), 32'd1);
    chk("jal0_fwd_data_hold", fwd_data, 32'h0000_4000);
    chk("jal_retire", retire_count, 32'd7);

    // Store with rvalid low never stalls
    drive(5'd3, 2'b10, 3'b010, 2'b00, 1'b0, 32'h40);
    #2;
    chk("store_stall", 32'(stall), 32'd0);
    chk("store_we", 32'(rf_we), 32'd0);
    tick();

    // Misaligned LW
    drive(5'd8, 2'b01, 3'b010, 2'b01, 1'b1, 32'h2);
    dmem_rvalid = 1'b1;
    #2;
    chk("mis_we", 32'(rf_we), 32'd0);
    tick();
    chk("mis_err", 32'(misaligned_err), 32'd1);
    chk("mis_retire", retire_count, 32'd9);
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(5'd9, 2'b00, 3'b000, 2'b00, 1'b1, 32'(i));
      tick();
    end
    chk("mis_sticky", 32'(misaligned_err), 32'd1);
    chk("clean_retire", retire_count, 32'd19);
    chk("clean_fwd_data", fwd_data, 32'd9);

    // Bubbles, one with a stray rvalid
    bubble();
    dmem_rvalid = 1'b1;
    #2;
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_we", 32'(rf_we), 32'd0);
    repeat (3) tick();
    chk("bubble_retire", retire_count, 32'd19);

    // Reset while waiting for load data
    drive(5'd10, 2'b01, 3'b010, 2'b01, 1'b1, 32'h0);
    dmem_rvalid = 1'b0;
    tick();
    chk("rstw_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bubble();
    dmem_rvalid = 1'b1;
    #2;
    chk("rstw_stall_after", 32'(stall), 32'd0);
    chk("rstw_retire", retire_count, 32'd0);
    chk("rstw_mis", 32'(misaligned_err), 32'd0);
    chk("rstw_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rstw_we", 32'(rf_we), 32'd0);
    tick();
    chk("rstw_fwd_valid2", 32'(fwd_valid), 32'd0);
    chk("rstw_retire2", retire_count, 32'd0);

    // RUN state: a non-load is unaffected by rvalid low
    drive(5'd11, 2'b00, 3'b000, 2'b00, 1'b1, 32'hCAFE);
    dmem_rvalid = 1'b0;
    #2;
    chk("run_stall", 32'(stall), 32'd0);
    chk("run_wdata", rf_wdata, 32'h0000_CAFE);
    tick();
    chk("run_retire", retire_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
